// File: rtl/chime_alarm_sequencer.sv
// chime_alarm_sequencer
//   Buzzer sequencer for the digital clock: hourly pre-beeps (low tone), a
//   top-of-hour final beep (high tone) and a user alarm (high-tone on/off
//   bursts, self-terminating after ALARM_REPS cycles).
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   chime_en, alarm_en  feature enables (dropping one aborts its sequence)
//   hour*/minute*/second*      current time, BCD digits
//   alarm_hour*/alarm_min*     alarm time, BCD digits
//   stop                single-cycle pulse silencing an active alarm
//   buzzer              registered square-wave buzzer drive
//   busy                any sequence active
//   alarm_active        alarm burst or gap in progress
module chime_alarm_sequencer #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int LOW_TONE_HZ  = 500,
  parameter int HIGH_TONE_HZ = 1000,
  parameter int PRE_BEEPS    = 5,
  parameter int BEEP_MS      = 200,
  parameter int FINAL_MS     = 1000,
  parameter int ALARM_ON_MS  = 250,
  parameter int ALARM_OFF_MS = 250,
  parameter int ALARM_REPS   = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       chime_en,
  input  logic       alarm_en,
  input  logic [3:0] hour1,
  input  logic [3:0] hour0,
  input  logic [3:0] minute1,
  input  logic [3:0] minute0,
  input  logic [3:0] second1,
  input  logic [3:0] second0,
  input  logic [3:0] alarm_hour1,
  input  logic [3:0] alarm_hour0,
  input  logic [3:0] alarm_min1,
  input  logic [3:0] alarm_min0,
  input  logic       stop,
  output logic       buzzer,
  output logic       busy,
  output logic       alarm_active
);

  localparam int LOW_HP    = CLK_HZ / (2 * LOW_TONE_HZ);
  localparam int HIGH_HP   = CLK_HZ / (2 * HIGH_TONE_HZ);
  localparam int MS_DIV    = CLK_HZ / 1000;
  localparam int MAX_AB    = (BEEP_MS > FINAL_MS) ? BEEP_MS : FINAL_MS;
  localparam int MAX_CD    = (ALARM_ON_MS > ALARM_OFF_MS) ? ALARM_ON_MS : ALARM_OFF_MS;
  localparam int MAX_MS    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int LW        = $clog2(LOW_HP + 1);
  localparam int HW        = $clog2(HIGH_HP + 1);
  localparam int DW        = $clog2(MS_DIV + 1);
  localparam int MW        = $clog2(MAX_MS + 1);
  localparam int RW        = $clog2(ALARM_REPS + 1);
  // First pre-beep second; 60 when PRE_BEEPS=0, which never matches.
  localparam int PRE_FIRST = 60 - 2 * PRE_BEEPS;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_FINAL, S_ALARM_ON, S_ALARM_OFF
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] low_cnt_q, low_cnt_d;
  logic [HW-1:0] high_cnt_q, high_cnt_d;
  logic [DW-1:0] ms_div_q, ms_div_d;
  logic [MW-1:0] ms_cnt_q, ms_cnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [7:0]    sec_q, sec_d;
  logic          low_tone_q, low_tone_d;
  logic          high_tone_q, high_tone_d;
  logic          buzzer_q, buzzer_d;

  logic       ms_tick, sec_edge, time_ok, in_alarm, in_chime;
  logic       ev_alarm, ev_final, ev_pre;
  logic [6:0] sec_bin;

  // Free-running tone toggles and millisecond prescaler.
  always_comb begin
    low_cnt_d   = low_cnt_q + 1'b1;
    low_tone_d  = low_tone_q;
    high_cnt_d  = high_cnt_q + 1'b1;
    high_tone_d = high_tone_q;
    ms_div_d    = ms_div_q + 1'b1;
    if (low_cnt_q == LW'(LOW_HP - 1)) begin
      low_cnt_d  = '0;
      low_tone_d = ~low_tone_q;
    end
    if (high_cnt_q == HW'(HIGH_HP - 1)) begin
      high_cnt_d  = '0;
      high_tone_d = ~high_tone_q;
    end
    if (ms_div_q == DW'(MS_DIV - 1)) ms_div_d = '0;
  end

  assign ms_tick = (ms_div_q == DW'(MS_DIV - 1));

  // Event decode, qualified by a change of the seconds digits.
  assign sec_d    = {second1, second0};
  assign sec_edge = (sec_d != sec_q);
  assign sec_bin  = 7'(second1) * 7'd10 + 7'(second0);
  assign time_ok  = (hour1 <= 4'd9) && (hour0 <= 4'd9) && (minute1 <= 4'd5) &&
                    (minute0 <= 4'd9) && (second1 <= 4'd5) && (second0 <= 4'd9);

  assign ev_alarm = sec_edge && time_ok && alarm_en && (sec_d == 8'h00) &&
                    ({hour1, hour0, minute1, minute0} ==
                     {alarm_hour1, alarm_hour0, alarm_min1, alarm_min0});
  assign ev_final = sec_edge && time_ok && chime_en && (sec_d == 8'h00) &&
                    ({minute1, minute0} == 8'h00);
  assign ev_pre   = sec_edge && time_ok && chime_en && ({minute1, minute0} == 8'h59) &&
                    !second0[0] && (sec_bin >= 7'(PRE_FIRST)) && (sec_bin <= 7'd58);

  assign in_alarm = (state_q == S_ALARM_ON) || (state_q == S_ALARM_OFF);
  assign in_chime = (state_q == S_PRE) || (state_q == S_FINAL);

  always_comb begin
    state_d  = state_q;
    ms_cnt_d = ms_tick ? ms_cnt_q + 1'b1 : ms_cnt_q;
    rep_d    = rep_q;
    if (ev_alarm && (!in_alarm || stop)) begin
      // Alarm start beats a coincident stop and any chime sequence.
      state_d  = S_ALARM_ON;
      ms_cnt_d = '0;
      rep_d    = '0;
    end else if (in_alarm && (stop || !alarm_en)) begin
      state_d  = S_IDLE;
      ms_cnt_d = '0;
    end else if (ev_final && !in_alarm) begin
      state_d  = S_FINAL;
      ms_cnt_d = '0;
    end else if (ev_pre && (state_q == S_IDLE || state_q == S_PRE)) begin
      state_d  = S_PRE;
      ms_cnt_d = '0;
    end else if (in_chime && !chime_en) begin
      state_d  = S_IDLE;
      ms_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: ms_cnt_d = '0;
        S_PRE:
          if (ms_tick && ms_cnt_q == MW'(BEEP_MS - 1)) begin
            state_d  = S_IDLE;
            ms_cnt_d = '0;
          end
        S_FINAL:
          if (ms_tick && ms_cnt_q == MW'(FINAL_MS - 1)) begin
            state_d  = S_IDLE;
            ms_cnt_d = '0;
          end
        S_ALARM_ON:
          if (ms_tick && ms_cnt_q == MW'(ALARM_ON_MS - 1)) begin
            state_d  = S_ALARM_OFF;
            ms_cnt_d = '0;
          end
        S_ALARM_OFF:
          if (ms_tick && ms_cnt_q == MW'(ALARM_OFF_MS - 1)) begin
            rep_d    = rep_q + 1'b1;
            ms_cnt_d = '0;
            state_d  = (rep_q == RW'(ALARM_REPS - 1)) ? S_IDLE : S_ALARM_ON;
          end
        default: begin
          state_d  = S_IDLE;
          ms_cnt_d = '0;
        end
      endcase
    end
  end

  // Buzzer follows the next state so stop/abort silence it on the same edge.
  always_comb begin
    buzzer_d = 1'b0;
    case (state_d)
      S_PRE:                buzzer_d = low_tone_q;
      S_FINAL, S_ALARM_ON:  buzzer_d = high_tone_q;
      default:              buzzer_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      low_cnt_q   <= '0;
      high_cnt_q  <= '0;
      ms_div_q    <= '0;
      ms_cnt_q    <= '0;
      rep_q       <= '0;
      sec_q       <= 8'h00;
      low_tone_q  <= 1'b0;
      high_tone_q <= 1'b0;
      buzzer_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      low_cnt_q   <= low_cnt_d;
      high_cnt_q  <= high_cnt_d;
      ms_div_q    <= ms_div_d;
      ms_cnt_q    <= ms_cnt_d;
      rep_q       <= rep_d;
      sec_q       <= sec_d;
      low_tone_q  <= low_tone_d;
      high_tone_q <= high_tone_d;
      buzzer_q    <= buzzer_d;
    end
  end

  assign buzzer       = buzzer_q;
  assign busy         = (state_q != S_IDLE);
  assign alarm_active = in_alarm;

endmodule

// File: tb/tb_chime_alarm_sequencer.sv
// Bench: two sequencers (PRE_BEEPS=5 and PRE_BEEPS=2) share one stimulus.
// Each time step is held for a window; the window's busy length, buzzer
// high count and longest buzzer-high run are compared against what the
// reference rules expect for that time.
module tb_chime_alarm_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic chime_en, alarm_en, stop;
  logic [3:0] hour1, hour0, minute1, minute0, second1, second0;
  logic [3:0] alarm_hour1, alarm_hour0, alarm_min1, alarm_min0;
  logic buz_a, busy_a, act_a, buz_b, busy_b, act_b;

  int tests = 0;
  int fails = 0;
  logic [7:0] prev_s;
  int bs[2], bh[2], mr[2], ac[2], be[2];

  always #5 clk = ~clk;

  chime_alarm_sequencer #(
    .CLK_HZ(100_000), .LOW_TONE_HZ(500), .HIGH_TONE_HZ(1000), .PRE_BEEPS(5),
    .BEEP_MS(2), .FINAL_MS(4), .ALARM_ON_MS(1), .ALARM_OFF_MS(1), .ALARM_REPS(3)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .chime_en(chime_en), .alarm_en(alarm_en),
    .hour1(hour1), .hour0(hour0), .minute1(minute1), .minute0(minute0),
    .second1(second1), .second0(second0),
    .alarm_hour1(alarm_hour1), .alarm_hour0(alarm_hour0),
    .alarm_min1(alarm_min1), .alarm_min0(alarm_min0),
    .stop(stop), .buzzer(buz_a), .busy(busy_a), .alarm_active(act_a)
  );

  chime_alarm_sequencer #(
    .CLK_HZ(100_000), .LOW_TONE_HZ(500), .HIGH_TONE_HZ(1000), .PRE_BEEPS(2),
    .BEEP_MS(2), .FINAL_MS(4), .ALARM_ON_MS(1), .ALARM_OFF_MS(1), .ALARM_REPS(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .chime_en(chime_en), .alarm_en(alarm_en),
    .hour1(hour1), .hour0(hour0), .minute1(minute1), .minute0(minute0),
    .second1(second1), .second0(second0),
    .alarm_hour1(alarm_hour1), .alarm_hour0(alarm_hour0),
    .alarm_min1(alarm_min1), .alarm_min0(alarm_min0),
    .stop(stop), .buzzer(buz_b), .busy(busy_b), .alarm_active(act_b)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no end of run, required finish before time limit");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Reference rules: 0 none, 1 pre-beep, 2 final beep, 3 alarm.
  function automatic int exp_kind(input int pre_beeps, input logic [23:0] t,
                                  input logic [7:0] ps, input logic ch,
                                  input logic al, input logic [15:0] at);
    int d[6];
    int mins, secs;
    if (t[7:0] == ps) return 0;
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(t[23 - 4*i -: 4]);
      if (d[i] > 9) return 0;
    end
    if (d[2] > 5 || d[4] > 5) return 0;
    mins = d[2] * 10 + d[3];
    secs = d[4] * 10 + d[5];
    if (al && t[23:8] == at && secs == 0) return 3;
    if (ch && mins == 0 && secs == 0) return 2;
    if (ch && mins == 59 && secs % 2 == 0 && secs >= 60 - 2 * pre_beeps && secs <= 58)
      return 1;
    return 0;
  endfunction

  task automatic set_time(input logic [23:0] t);
    {hour1, hour0, minute1, minute0, second1, second0} = t;
    prev_s = t[7:0];
  endtask

  task automatic meas(input int n);
    int run[2];
    logic [1:0] bz, by, av;
    for (int i = 0; i < 2; i++) begin
      bs[i] = 0; bh[i] = 0; mr[i] = 0; ac[i] = 0; run[i] = 0;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bz = {buz_b, buz_a};
      by = {busy_b, busy_a};
      av = {act_b, act_a};
      for (int i = 0; i < 2; i++) begin
        if (by[i]) bs[i]++;
        if (av[i]) ac[i]++;
        if (bz[i]) begin
          bh[i]++;
          run[i]++;
          if (run[i] > mr[i]) mr[i] = run[i];
        end else run[i] = 0;
        be[i] = int'(by[i]);
      end
    end
  endtask

  task automatic check_kind(input string tag, input int i, input int k);
    string p;
    p = $sformatf("%s/%s", tag, (i == 0) ? "pb5" : "pb2");
    case (k)
      0: begin
        chk_eq({p, "/busy_cycles"}, bs[i], 0);
        chk_eq({p, "/buzzer_high"}, bh[i], 0);
      end
      1: begin
        chk_rng({p, "/pre_len"}, bs[i], 100, 201);
        chk_rng({p, "/pre_tone_run"}, mr[i], 1, 100);
        chk_eq({p, "/pre_alarm_active"}, ac[i], 0);
      end
      2: begin
        chk_rng({p, "/final_len"}, bs[i], 300, 401);
        chk_eq({p, "/final_tone_run"}, mr[i], 50);
        chk_eq({p, "/final_alarm_active"}, ac[i], 0);
      end
      default: begin
        chk_rng({p, "/alarm_len"}, ac[i], 500, 601);
        chk_eq({p, "/alarm_busy_vs_active"}, bs[i], ac[i]);
        chk_rng({p, "/alarm_buzzer_high"}, bh[i], 100, 150);
      end
    endcase
    chk_eq({p, "/idle_at_end"}, be[i], 0);
  endtask

  task automatic step(input string tag, input logic [23:0] t);
    int ka, kb;
    ka = exp_kind(5, t, prev_s, chime_en, alarm_en,
                  {alarm_hour1, alarm_hour0, alarm_min1, alarm_min0});
    kb = exp_kind(2, t, prev_s, chime_en, alarm_en,
                  {alarm_hour1, alarm_hour0, alarm_min1, alarm_min0});
    set_time(t);
    meas(700 + int'($urandom_range(0, 60)));
    check_kind(tag, 0, ka);
    check_kind(tag, 1, kb);
  endtask

  initial begin
    logic [23:0] t;
    int k;
    rst_n = 1'b0; chime_en = 1'b0; alarm_en = 1'b0; stop = 1'b0;
    {hour1, hour0, minute1, minute0, second1, second0} = '0;
    {alarm_hour1, alarm_hour0, alarm_min1, alarm_min0} = '0;
    prev_s = 8'h00;
    repeat (3) @(negedge clk);
    chk_eq("reset/buzzer", int'(buz_a), 0);
    chk_eq("reset/busy", int'(busy_a), 0);
    chk_eq("reset/alarm_active", int'(act_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a final beep.
    chime_en = 1'b1;
    step("pre_final", 24'h235959);
    set_time(24'h000000);
    repeat (50) @(negedge clk);
    chk_eq("mid_final/busy", int'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    chk_eq("mid_final_rst/buzzer", int'(buz_a), 0);
    chk_eq("mid_final_rst/busy", int'(busy_a), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    meas(600);
    chk_eq("after_rst/busy_cycles", bs[0], 0);
    chk_eq("after_rst/buzzer_high", bh[0], 0);

    // Hourly chime walk: 10:59:49 .. 10:59:59, then 11:00:00.
    for (int s = 49; s <= 59; s++) step($sformatf("chime_59_%0d", s), {16'h1059, bcd(s)});
    step("chime_top", 24'h110000);

    // Alarm at 07:30, full self-terminating pattern.
    chime_en = 1'b0; alarm_en = 1'b1;
    {alarm_hour1, alarm_hour0, alarm_min1, alarm_min0} = 16'h0730;
    step("alarm_pre", 24'h072959);
    step("alarm_0730", 24'h073000);

    // Alarm at 00:00 outranks the final beep.
    chime_en = 1'b1;
    {alarm_hour1, alarm_hour0, alarm_min1, alarm_min0} = 16'h0000;
    step("prio_pre", 24'h235959);
    step("prio_0000", 24'h000000);

    // stop pulse during a burst.
    {alarm_hour1, alarm_hour0, alarm_min1, alarm_min0} = 16'h0815;
    step("stop_pre", 24'h081459);
    set_time(24'h081500);
    k = 0;
    while (k < 200 && buz_a !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chk_eq("stop/burst_seen", int'(buz_a), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk_eq("stop/buzzer", int'(buz_a), 0);
    chk_eq("stop/alarm_active", int'(act_a), 0);
    chk_eq("stop/busy", int'(busy_a), 0);
    meas(700);
    chk_eq("stop/quiet_after", bs[0], 0);

    // Invalid digits suppress events.
    alarm_en = 1'b0;
    step("inv_pre", 24'h125949);
    step("inv_sec0_A", 24'h12594A);
    step("inv_sec1_7", 24'h125970);
    step("inv_min1_6", 24'h126950);

    // chime_en dropped during a pre-beep.
    step("drop_pre", 24'h135949);
    set_time(24'h135950);
    k = 0;
    while (k < 10 && busy_a !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chk_eq("drop/pre_started", int'(busy_a), 1);
    repeat (20) @(negedge clk);
    chime_en = 1'b0;
    @(negedge clk);
    chk_eq("drop/buzzer", int'(buz_a), 0);
    chk_eq("drop/busy", int'(busy_a), 0);
    meas(300);
    chime_en = 1'b1;

    // Randomised times against the reference rules.
    for (int it = 0; it < 10; it++) begin
      chime_en = 1'($urandom_range(0, 1));
      alarm_en = 1'($urandom_range(0, 1));
      {alarm_hour1, alarm_hour0, alarm_min1, alarm_min0} =
        {bcd(int'($urandom_range(0, 23))), bcd(int'($urandom_range(0, 59)))};
      case ($urandom_range(0, 3))
        0: t = {bcd(int'($urandom_range(0, 23))), 8'h59, bcd(int'($urandom_range(48, 59)))};
        1: t = {bcd(int'($urandom_range(0, 23))), 16'h0000};
        2: t = {alarm_hour1, alarm_hour0, alarm_min1, alarm_min0, 8'h00};
        default: begin
          for (int d = 0; d < 6; d++) t[4*d +: 4] = 4'($urandom_range(0, 15));
        end
      endcase
      step($sformatf("rand_%0d_%h", it, t), t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
